p4_adder_pipe: RTL
==================

# p4_adder_pipe

Pipelined, flow-controlled P4 adder that consumes operand requests (a, b, cin) and produces sum responses (s, cout). The carry chain is split across STAGES register slices, giving one result per cycle at STAGES-cycle latency. It is the responder side of the p4_adder request/response protocol. It sits between an operand source (driver or upstream datapath) and a result sink (monitor or downstream datapath), and applies valid/ready backpressure on both ends.

## Interface
Parameters:
- NBIT, default p4_adder_pkg::NBIT (32): operand and sum width.
- STAGES, default 2: pipeline depth and number of carry slices. Legal range 1..8; NBIT mod STAGES must be 0. Elaboration fails otherwise.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present on a, b, cin.
- req_ready  out  1  block accepts the request this cycle.
- a  in  NBIT  operand A.
- b  in  NBIT  operand B.
- cin  in  1  carry in.
- rsp_valid  out  1  s and cout hold a valid result.
- rsp_ready  in  1  sink accepts the result this cycle.
- s  out  NBIT  sum, (a + b + cin) mod 2^NBIT.
- cout  out  1  carry out of bit NBIT-1.

## Operation
- A transfer occurs on a rising edge where valid && ready holds; this applies to both the request and the response port.
- Slice width W = NBIT/STAGES. Stage k (1..STAGES) adds bits [k*W-1:(k-1)*W] using the carry from stage k-1. Stage 1 uses cin.
- Each stage register holds:
  - a valid bit,
  - sum bits completed so far,
  - the carry out of its slice,
  - the not-yet-added upper bits of a and b.
- Per-stage advance rule: ready_k = !valid_k || ready_{k+1}, with ready_{STAGES+1} = rsp_ready. This makes req_ready = ready_1, a combinational path from rsp_ready through the stage valids. No combinational path exists from req_valid to req_ready.
- Output: rsp_valid = valid_STAGES, and {cout, s} come from the stage STAGES register. If rsp_valid && !rsp_ready, s and cout stay constant until the transfer.
- Ordering: responses leave strictly in request order. No drops, no duplicates.
- Capacity: exactly STAGES requests in flight. When all stages are valid and rsp_ready=0, req_ready=0.
- Arithmetic: unsigned modular sum; cout is the true 33rd bit for NBIT=32. No overflow flag.

## Timing
- Reset values: all stage valids 0, all data registers 0, so rsp_valid=0, s=0, cout=0.
- req_ready is forced to 0 while rst=1. The first cycle after release it is 1 (pipeline empty).
- rst asserted mid-operation clears every in-flight request asynchronously. rsp_valid falls in the same cycle, without waiting for a clock. Nothing in flight is ever emitted.
- Latency: a request accepted at edge t produces rsp_valid=1 after edge t+STAGES-1, so the response is visible in the cycle following edge t+STAGES-1. For STAGES=1, rsp_valid is high the cycle after acceptance.
- Throughput: 1 transfer/cycle with rsp_ready held at 1.
- Simultaneous events: with the pipeline full and rsp_ready=1, a new request is accepted on the same edge the oldest response leaves.
- The bench samples outputs before the falling clock edge and drives inputs right after the rising edge. All outputs are therefore registered or depend only on registers and rsp_ready.

## Structure
- p4_adder_pkg contains:
  - NBIT
  - data_t (logic [NBIT-1:0])
  - a packed stage-payload struct type parameterised by the slice index via generate-sized fields, or flattened to NBIT-wide fields plus carry.
- Sub-module p4_adder_slice: one W-bit add plus its stage register, valid bit and ready logic. p4_adder_pipe instantiates it STAGES times in a generate loop.

## Test plan
All scenarios use NBIT=32, STAGES=2.
- Reset: hold rst for 3 cycles, then release → rsp_valid=0, s=0, cout=0, and req_ready=1 in the first cycle after release.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → s=0x0000_0000, cout=1, with rsp_valid 2 edges after acceptance.
- Slice boundary: a=0x0000_FFFF, b=0x0000_0001, cin=0 → s=0x0001_0000, cout=0. Then a=0, b=0, cin=1 → s=0x0000_0001, cout=0.
- Streaming: 8 back-to-back random requests with rsp_ready=1 → 8 responses on consecutive cycles, in order, each matching the reference sum.
- Backpressure: rsp_ready=0 for 5 cycles while req_valid=1:
  - exactly 2 requests are accepted, then req_ready=0;
  - s and cout stay stable while stalled;
  - after rsp_ready=1, all requests drain in order with no loss or duplication.
- Reset in flight: 2 requests pending, rst pulsed between edges → rsp_valid drops immediately, and no response for those requests appears after release.

Source files
------------

// File: rtl/p4_adder_pkg.sv
// Shared width, data type and stage payload for the pipelined P4 adder.
// The legality check lives here so every user applies the same NBIT/STAGES rule.
package p4_adder_pkg;

  localparam int NBIT       = 32;
  localparam int MAX_STAGES = 8;

  typedef logic [NBIT-1:0] data_t;

  // Flattened stage payload: full-width fields, with sum filled in slice by slice.
  typedef struct packed {
    logic  valid;
    logic  carry;
    data_t sum;
    data_t a;
    data_t b;
  } stage_pl_t;

  function automatic bit stages_legal(input int nbit, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) && ((nbit % stages) == 0);
  endfunction

endpackage

// File: rtl/p4_adder_slice.sv
// One carry slice: adds W bits at offset OFF and registers the partial result.
// The stage can load whenever it is empty or its contents leave this cycle.
module p4_adder_slice
  import p4_adder_pkg::*;
#(
  parameter int NBIT = 32,
  parameter int W    = 16,
  parameter int OFF  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic            i_carry,
  input  logic [NBIT-1:0] i_sum,
  input  logic [NBIT-1:0] i_a,
  input  logic [NBIT-1:0] i_b,
  input  logic            i_dn_ready,
  output logic            o_up_ready,
  output logic            o_valid,
  output logic            o_carry,
  output logic [NBIT-1:0] o_sum,
  output logic [NBIT-1:0] o_a,
  output logic [NBIT-1:0] o_b
);

  logic            r_valid;
  logic            r_carry;
  logic [NBIT-1:0] r_sum;
  logic [NBIT-1:0] r_a;
  logic [NBIT-1:0] r_b;

  logic [W:0]      w_add;
  logic [NBIT-1:0] w_sum;

  assign w_add = {1'b0, i_a[OFF +: W]} + {1'b0, i_b[OFF +: W]} + {{W{1'b0}}, i_carry};

  always_comb begin
    w_sum            = i_sum;
    w_sum[OFF +: W]  = w_add[W-1:0];
  end

  assign o_up_ready = !r_valid || i_dn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (o_up_ready) begin
      r_valid <= i_valid;
      // Data only moves with a real request so a stalled result never changes.
      if (i_valid) begin
        r_carry <= w_add[W];
        r_sum   <= w_sum;
        r_a     <= i_a;
        r_b     <= i_b;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_carry = r_carry;
  assign o_sum   = r_sum;
  assign o_a     = r_a;
  assign o_b     = r_b;

endmodule

// File: rtl/p4_adder_pipe.sv
// Pipelined valid/ready adder: the carry chain is cut into STAGES registered slices.
// req_ready depends only on stage valids, rsp_ready and rst, never on req_valid.
module p4_adder_pipe
  import p4_adder_pkg::*;
#(
  parameter int NBIT   = p4_adder_pkg::NBIT,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            cin,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [NBIT-1:0] s,
  output logic            cout
);

  if (!stages_legal(NBIT, STAGES)) begin : g_bad_cfg
    $error("p4_adder_pipe: STAGES must be 1..8 and divide NBIT");
  end

  localparam int W = NBIT / STAGES;

  // Index k is the input of slice k and the output of slice k-1.
  logic            w_valid [0:STAGES];
  logic            w_ready [0:STAGES];
  logic            w_carry [0:STAGES];
  logic [NBIT-1:0] w_sum   [0:STAGES];
  logic [NBIT-1:0] w_a     [0:STAGES];
  logic [NBIT-1:0] w_b     [0:STAGES];

  assign w_valid[0]      = req_valid;
  assign w_carry[0]      = cin;
  assign w_sum[0]        = '0;
  assign w_a[0]          = a;
  assign w_b[0]          = b;
  assign w_ready[STAGES] = rsp_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    p4_adder_slice #(
      .NBIT (NBIT),
      .W    (W),
      .OFF  (k * W)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (w_valid[k]),
      .i_carry    (w_carry[k]),
      .i_sum      (w_sum[k]),
      .i_a        (w_a[k]),
      .i_b        (w_b[k]),
      .i_dn_ready (w_ready[k+1]),
      .o_up_ready (w_ready[k]),
      .o_valid    (w_valid[k+1]),
      .o_carry    (w_carry[k+1]),
      .o_sum      (w_sum[k+1]),
      .o_a        (w_a[k+1]),
      .o_b        (w_b[k+1])
    );
  end

  // Stages read empty during reset, so the port must be masked explicitly.
  assign req_ready = !rst && w_ready[0];
  assign rsp_valid = w_valid[STAGES];
  assign s         = w_sum[STAGES];
  assign cout      = w_carry[STAGES];

endmodule
